divmod_recompose: RTL

//  Multi-cycle inverse of the div/mod datapath: rebuilds dividend A = Q*B + R

---
 rtl/divmod_recompose.sv | 104 ++++++++++
 1 files changed

// File: rtl/divmod_recompose.sv
// divmod_recompose: rebuilds A = Q*B + R with a bit-serial shift-add multiplier
// followed by a single wide add; Start/Done handshake, results held until next Start.
module divmod_recompose #(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Start,
  input  logic [DATAWIDTH-1:0] Q,
  input  logic [DATAWIDTH-1:0] B,
  input  logic [DATAWIDTH-1:0] R,
  output logic                 Busy,
  output logic                 Done,
  output logic [DATAWIDTH-1:0] A,
  output logic                 Ovf,
  output logic                 RemErr
);

  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] LASTBIT = CW'(DATAWIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} stateT;

  stateT                  stateReg;
  stateT                  stateNext;
  logic [DATAWIDTH-1:0]   qReg;
  logic [DATAWIDTH-1:0]   rReg;
  logic [DATAWIDTH-1:0]   aReg;
  logic [2*DATAWIDTH-1:0] bShiftReg;
  logic [2*DATAWIDTH-1:0] accReg;
  logic [CW-1:0]          countReg;
  logic                   ovfReg;
  logic                   remErrReg;
  logic [2*DATAWIDTH:0]   sum;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (Start) stateNext = MUL;
      MUL:     if (countReg == LASTBIT) stateNext = ADD;
      ADD:     stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // One extra top bit so a carry out of the 2W-bit product is still seen as overflow.
  assign sum = {1'b0, accReg} + {{(DATAWIDTH+1){1'b0}}, rReg};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      qReg      <= '0;
      rReg      <= '0;
      aReg      <= '0;
      bShiftReg <= '0;
      accReg    <= '0;
      countReg  <= '0;
      ovfReg    <= 1'b0;
      remErrReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (Start) begin
            qReg      <= Q;
            rReg      <= R;
            bShiftReg <= {{DATAWIDTH{1'b0}}, B};
            accReg    <= '0;
            countReg  <= '0;
            remErrReg <= (R >= B);
          end
        end
        MUL: begin
          // Multiplier consumed LSB first; B pre-shifted so it lands at weight 2^count.
          if (qReg[0]) accReg <= accReg + bShiftReg;
          qReg      <= qReg >> 1;
          bShiftReg <= bShiftReg << 1;
          countReg  <= countReg + CW'(1);
        end
        ADD: begin
          aReg   <= sum[DATAWIDTH-1:0];
          ovfReg <= |sum[2*DATAWIDTH:DATAWIDTH];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    Busy   = (stateReg != IDLE);
    Done   = (stateReg == DONE);
    A      = aReg;
    Ovf    = ovfReg;
    RemErr = remErrReg;
  end

endmodule
